// File: rtl/jtframe_inputs.sv
// rtl/jtframe_inputs.sv - game input conditioner: polarity, coin stretch, autofire, pause toggle
module jtframe_inputs #(
    parameter int NPLAYERS     = 2,
    parameter int BUTTONS      = 2,
    parameter int ACTIVE_LOW   = 1,
    parameter int COIN_FRAMES  = 4,
    parameter int AUTOFIRE_DIV = 2
) (
    input  logic                           rst,
    input  logic                           clk,
    input  logic                           LVBL,
    input  logic [NPLAYERS*16-1:0]         board_joy,
    input  logic [BUTTONS-1:0]             autofire_en,
    output logic [NPLAYERS*(4+BUTTONS)-1:0] game_joy,
    output logic [NPLAYERS-1:0]            game_coin,
    output logic [NPLAYERS-1:0]            game_start,
    output logic                           game_service,
    output logic                           dip_pause,
    output logic                           frame_tick
);

    localparam int JW = 4 + BUTTONS;

    logic [NPLAYERS*16-1:0]      joy_a;
    logic [NPLAYERS-1:0]         coin_b, pause_b;
    logic                        primed;
    logic                        lvbl_r;
    logic [3:0]                  fcnt;
    logic                        phase;
    logic [NPLAYERS-1:0][3:0]    coin_cnt;
    logic [NPLAYERS*JW-1:0]      joy_r, joy_nx;
    logic [NPLAYERS-1:0]         start_r, start_nx;
    logic                        service_r;
    logic [NPLAYERS-1:0]         coin_a, pause_a, coin_raw, pause_raw;
    logic [NPLAYERS-1:0]         coin_rise, pause_rise, coin_on;
    logic                        unused_bits;

    assign unused_bits = ^joy_a;

    always_comb begin
        joy_nx    = '0;
        start_nx  = '0;
        coin_a    = '0;
        pause_a   = '0;
        coin_raw  = '0;
        pause_raw = '0;
        coin_on   = '0;
        for (int p = 0; p < NPLAYERS; p++) begin
            joy_nx[p*JW +: 4] = joy_a[p*16 +: 4];
            for (int b = 0; b < BUTTONS; b++)
                joy_nx[p*JW+4+b] = joy_a[p*16+4+b] & (phase | ~autofire_en[b]);
            start_nx[p]  = joy_a[p*16+11];
            coin_a[p]    = joy_a[p*16+10];
            pause_a[p]   = joy_a[p*16+13];
            coin_raw[p]  = board_joy[p*16+10];
            pause_raw[p] = board_joy[p*16+13];
            coin_on[p]   = coin_cnt[p] != 4'd0;
        end
    end

    assign coin_rise  = coin_a & ~coin_b;
    assign pause_rise = pause_a & ~pause_b;

    // On the first clock after reset stage B is loaded straight from the board,
    // so inputs held across reset release never look like fresh presses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            primed     <= 1'b0;
            joy_a      <= '0;
            coin_b     <= '0;
            pause_b    <= '0;
            lvbl_r     <= 1'b1;
            frame_tick <= 1'b0;
            fcnt       <= 4'd0;
            phase      <= 1'b1;
            joy_r      <= '0;
            start_r    <= '0;
            service_r  <= 1'b0;
            dip_pause  <= 1'b0;
        end else begin
            primed     <= 1'b1;
            joy_a      <= board_joy;
            coin_b     <= primed ? coin_a  : coin_raw;
            pause_b    <= primed ? pause_a : pause_raw;
            lvbl_r     <= LVBL;
            frame_tick <= lvbl_r & ~LVBL;
            if (frame_tick) begin
                if (fcnt == 4'(AUTOFIRE_DIV - 1)) begin
                    fcnt  <= 4'd0;
                    phase <= ~phase;
                end else begin
                    fcnt  <= fcnt + 4'd1;
                end
            end
            joy_r     <= joy_nx;
            start_r   <= start_nx;
            service_r <= joy_a[12];
            if (|pause_rise)
                dip_pause <= ~dip_pause;
        end
    end

    // A press while a pulse is running is ignored; a press on a tick cycle loads without decrementing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coin_cnt <= '0;
        end else begin
            for (int p = 0; p < NPLAYERS; p++) begin
                if (coin_rise[p] && !coin_on[p])
                    coin_cnt[p] <= 4'(COIN_FRAMES);
                else if (frame_tick && coin_on[p])
                    coin_cnt[p] <= coin_cnt[p] - 4'd1;
            end
        end
    end

    generate
        if (ACTIVE_LOW != 0) begin : g_low
            assign game_joy     = ~joy_r;
            assign game_coin    = ~coin_on;
            assign game_start   = ~start_r;
            assign game_service = ~service_r;
        end else begin : g_high
            assign game_joy     = joy_r;
            assign game_coin    = coin_on;
            assign game_start   = start_r;
            assign game_service = service_r;
        end
    endgenerate

endmodule

// File: tb/tb_jtframe_inputs.sv
// tb/tb_jtframe_inputs.sv - directed bench for jtframe_inputs
module tb_jtframe_inputs;

    logic        rst, clk, LVBL;
    logic [31:0] board_joy;
    logic [1:0]  autofire_en;
    logic [11:0] game_joy;
    logic [1:0]  game_coin, game_start;
    logic        game_service, dip_pause, frame_tick;

    int checks = 0;
    int errors = 0;

    jtframe_inputs #(
        .NPLAYERS(2), .BUTTONS(2), .ACTIVE_LOW(1), .COIN_FRAMES(4), .AUTOFIRE_DIV(2)
    ) dut (
        .rst(rst), .clk(clk), .LVBL(LVBL), .board_joy(board_joy),
        .autofire_en(autofire_en), .game_joy(game_joy), .game_coin(game_coin),
        .game_start(game_start), .game_service(game_service),
        .dip_pause(dip_pause), .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // one LVBL falling edge -> exactly one frame_tick, consumed before returning
    task automatic frame();
        LVBL = 1'b0;
        step(1);
        LVBL = 1'b1;
        step(3);
    endtask

    initial begin
        rst = 1'b1; LVBL = 1'b1; board_joy = '0; autofire_en = 2'b01;
        step(2);
        check("rst_joy", game_joy, 12'hfff);
        check("rst_coin", game_coin, 2'b11);
        check("rst_start", game_start, 2'b11);
        check("rst_service", game_service, 1'b1);
        check("rst_pause", dip_pause, 1'b0);
        check("rst_tick", frame_tick, 1'b0);
        rst = 1'b0;
        step(1);

        // latency: 2 clk
        board_joy = 32'h0000_0001;
        step(1);
        check("right_1clk", game_joy[0], 1'b1);
        step(1);
        check("right_2clk", game_joy[0], 1'b0);
        board_joy = 32'h0800_1000;
        step(2);
        check("start_p1", game_start, 2'b01);
        check("service_p0", game_service, 1'b0);
        check("right_rel", game_joy[0], 1'b1);
        board_joy = '0;
        step(2);
        check("idle_joy", game_joy, 12'hfff);

        // autofire: phase starts at 1, toggles every 2 ticks
        board_joy = 32'h0000_0030;
        step(2);
        check("af_t0", game_joy[5:4], 2'b00);
        frame();
        check("af_t1", game_joy[5:4], 2'b00);
        frame();
        check("af_t2", game_joy[5:4], 2'b01);
        frame();
        frame();
        check("af_t4", game_joy[5:4], 2'b00);
        frame();
        frame();
        check("af_t6", game_joy[5:4], 2'b01);
        autofire_en = 2'b00;
        step(1);
        check("af_dis", game_joy[5:4], 2'b00);
        autofire_en = 2'b01;
        board_joy = '0;
        step(2);

        // coin stretch, p1
        board_joy = 32'h0400_0000;
        step(1);
        board_joy = '0;
        step(1);
        check("coin_start", game_coin, 2'b01);
        frame();
        board_joy = 32'h0400_0000;
        step(1);
        board_joy = '0;
        step(1);
        frame();
        frame();
        check("coin_f3", game_coin, 2'b01);
        frame();
        check("coin_f4", game_coin, 2'b11);
        frame();
        frame();
        check("coin_f6", game_coin, 2'b11);

        // coin edge coinciding with frame_tick
        board_joy = 32'h0400_0000;
        LVBL = 1'b0;
        step(1);
        check("tick_same", frame_tick, 1'b1);
        board_joy = '0;
        LVBL = 1'b1;
        step(3);
        check("coin_tk0", game_coin, 2'b01);
        frame();
        frame();
        frame();
        check("coin_tk3", game_coin, 2'b01);
        frame();
        check("coin_tk4", game_coin, 2'b11);

        // pause
        board_joy = 32'h2000_2000;
        step(2);
        check("pause_on", dip_pause, 1'b1);
        step(2);
        check("pause_hold", dip_pause, 1'b1);
        LVBL = 1'b0;
        step(1);
        check("tick_paused", frame_tick, 1'b1);
        LVBL = 1'b1;
        step(1);
        check("tick_end", frame_tick, 1'b0);
        board_joy = '0;
        step(2);
        board_joy = 32'h0000_2000;
        step(2);
        check("pause_off", dip_pause, 1'b0);
        board_joy = '0;
        step(2);
        board_joy = 32'h2000_0000;
        step(2);
        check("pause_p1", dip_pause, 1'b1);
        board_joy = '0;
        step(2);

        // reset mid coin pulse and mid pause, coin held across release
        board_joy = 32'h0000_0400;
        step(1);
        check("coin_p0", game_coin, 2'b11);
        step(1);
        check("coin_p0_on", game_coin, 2'b10);
        rst = 1'b1;
        #1;
        check("rst_mid_coin", game_coin, 2'b11);
        check("rst_mid_pause", dip_pause, 1'b0);
        step(1);
        rst = 1'b0;
        step(1);
        step(3);
        check("held_no_pulse", game_coin, 2'b11);
        board_joy = '0;
        step(2);
        board_joy = 32'h0000_0400;
        step(2);
        check("repress_pulse", game_coin, 2'b10);
        board_joy = '0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
